// File: rtl/memwr_arbiter.sv
// Round-robin arbiter sharing the inb_* memory command bus between two requesters.
// Read ownership is tracked in issue order so that returning data can be routed back.
module memwr_arbiter #(
  parameter int P_DATA_NBIT       = 32,
  parameter int P_ADDR_NBIT       = 24,
  parameter int P_MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m0_req,
  input  logic                   m0_write,
  input  logic [P_ADDR_NBIT-1:0] m0_address,
  input  logic [P_DATA_NBIT-1:0] m0_wdata,
  output logic                   m0_ack,
  output logic [P_DATA_NBIT-1:0] m0_rdata,
  output logic                   m0_rdatavalid,
  input  logic                   m1_req,
  input  logic                   m1_write,
  input  logic [P_ADDR_NBIT-1:0] m1_address,
  input  logic [P_DATA_NBIT-1:0] m1_wdata,
  output logic                   m1_ack,
  output logic [P_DATA_NBIT-1:0] m1_rdata,
  output logic                   m1_rdatavalid,
  output logic [P_ADDR_NBIT-1:0] inb_address,
  output logic                   inb_write,
  output logic [P_DATA_NBIT-1:0] inb_wdata,
  output logic                   inb_read,
  input  logic [P_DATA_NBIT-1:0] inb_rdata,
  input  logic                   inb_datavalid,
  input  logic                   inb_initdone,
  output logic                   busy,
  output logic                   err_orphan
);

  localparam int CW = $clog2(P_MAX_OUTSTANDING);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(P_MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   wr_q, wr_d;
  logic [P_ADDR_NBIT-1:0] addr_q, addr_d;
  logic [P_DATA_NBIT-1:0] wdata_q, wdata_d;
  logic                   last_owner_q, last_owner_d;

  logic                   tag_mem_q [P_MAX_OUTSTANDING];
  logic [CW-1:0]          wptr_q, rptr_q;
  logic [CW:0]            count_q;
  logic                   err_q;
  logic                   rdv0_q, rdv1_q;
  logic [P_DATA_NBIT-1:0] rdata_q;

  logic fifo_full, elig0, elig1, grant_valid, grant_id, accept, push, pop, head_tag;

  // Full is judged on the registered count, so a same-cycle pop does not free a slot yet.
  assign fifo_full = (count_q == FULL_CNT);
  assign elig0     = m0_req & (m0_write | ~fifo_full);
  assign elig1     = m1_req & (m1_write | ~fifo_full);
  assign accept    = (state_q == S_ISSUE) & inb_initdone;
  assign push      = accept & ~wr_q;
  assign pop       = inb_datavalid & (count_q != '0);
  assign head_tag  = tag_mem_q[rptr_q];

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_owner_d = last_owner_q;
    grant_valid  = 1'b0;
    grant_id     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig0 && elig1) begin
          grant_valid = 1'b1;
          grant_id    = ~last_owner_q;
        end else if (elig0 || elig1) begin
          grant_valid = 1'b1;
          grant_id    = elig1;
        end
        if (grant_valid) begin
          state_d      = S_ISSUE;
          owner_d      = grant_id;
          last_owner_d = grant_id;
          wr_d         = grant_id ? m1_write   : m0_write;
          addr_d       = grant_id ? m1_address : m0_address;
          wdata_d      = grant_id ? m1_wdata   : m0_wdata;
        end
      end
      S_ISSUE: begin
        if (inb_initdone) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_owner_q <= 1'b1;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      rdv0_q       <= 1'b0;
      rdv1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_owner_q <= last_owner_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (inb_datavalid && count_q == '0) err_q <= 1'b1;
      rdv0_q <= pop & ~head_tag;
      rdv1_q <= pop & head_tag;
      if (pop) rdata_q <= inb_rdata;
    end
  end

  // Tag storage carries no reset; validity is governed entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wptr_q] <= owner_q;
  end

  assign inb_write     = (state_q == S_ISSUE) & wr_q;
  assign inb_read      = (state_q == S_ISSUE) & ~wr_q;
  assign inb_address   = addr_q;
  assign inb_wdata     = wdata_q;
  assign m0_ack        = accept & ~owner_q;
  assign m1_ack        = accept & owner_q;
  assign m0_rdata      = rdata_q;
  assign m1_rdata      = rdata_q;
  assign m0_rdatavalid = rdv0_q;
  assign m1_rdatavalid = rdv1_q;
  assign busy          = (state_q == S_ISSUE) | (count_q != '0);
  assign err_orphan    = err_q;

endmodule

// File: tb/tb_memwr_arbiter.sv
// Randomized bench for memwr_arbiter: a transaction-level model (in-flight command plus
// a queue of read owners) predicts every output each cycle; a few literal checks pin it.
module tb_memwr_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 24;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_address, m1_address;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack, m0_rdatavalid, m1_rdatavalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] inb_address;
  logic          inb_write, inb_read;
  logic [DW-1:0] inb_wdata;
  logic [DW-1:0] inb_rdata;
  logic          inb_datavalid, inb_initdone;
  logic          busy, err_orphan;

  memwr_arbiter #(.P_DATA_NBIT(DW), .P_ADDR_NBIT(AW), .P_MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rdatavalid(m0_rdatavalid),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rdatavalid(m1_rdatavalid),
    .inb_address(inb_address), .inb_write(inb_write), .inb_wdata(inb_wdata),
    .inb_read(inb_read), .inb_rdata(inb_rdata), .inb_datavalid(inb_datavalid),
    .inb_initdone(inb_initdone), .busy(busy), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state: what the DUT holds after the most recent clock edge.
  bit            m_in_flight = 1'b0;
  bit            m_owner = 1'b0;
  bit            m_w = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  bit            m_last = 1'b1;
  bit            m_err = 1'b0;
  bit            m_rdv0 = 1'b0, m_rdv1 = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            tagq[$];
  bit            ack_seen0 = 1'b0, ack_seen1 = 1'b0;
  int            grants0 = 0, grants1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit ea0, ea1, e0, e1, full, g;
    int head;
    ea0 = m_in_flight && inb_initdone && !m_owner;
    ea1 = m_in_flight && inb_initdone && m_owner;
    if (chk_en) begin
      chk("inb_write", inb_write, m_in_flight && m_w);
      chk("inb_read", inb_read, m_in_flight && !m_w);
      if (m_in_flight) begin
        chk("inb_address", inb_address, m_addr);
        chk("inb_wdata", inb_wdata, m_wdata);
      end
      chk("m0_ack", m0_ack, ea0);
      chk("m1_ack", m1_ack, ea1);
      chk("m0_rdatavalid", m0_rdatavalid, m_rdv0);
      chk("m1_rdatavalid", m1_rdatavalid, m_rdv1);
      if (m_rdv0) chk("m0_rdata", m0_rdata, m_rdata);
      if (m_rdv1) chk("m1_rdata", m1_rdata, m_rdata);
      chk("busy", busy, m_in_flight || tagq.size() != 0);
      chk("err_orphan", err_orphan, m_err);
    end
    ack_seen0 = ea0;
    ack_seen1 = ea1;
    // Advance the model across the coming rising edge.
    if (!rst_n) begin
      m_in_flight = 1'b0; m_owner = 1'b0; m_w = 1'b0; m_addr = '0; m_wdata = '0;
      m_last = 1'b1; m_err = 1'b0; m_rdv0 = 1'b0; m_rdv1 = 1'b0; m_rdata = '0;
      tagq.delete();
    end else begin
      full = (tagq.size() >= MAXO);
      m_rdv0 = 1'b0;
      m_rdv1 = 1'b0;
      if (inb_datavalid) begin
        if (tagq.size() != 0) begin
          head = tagq.pop_front();
          if (head == 0) m_rdv0 = 1'b1; else m_rdv1 = 1'b1;
          m_rdata = inb_rdata;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_in_flight) begin
        if (inb_initdone) begin
          if (!m_w) tagq.push_back(int'(m_owner));
          m_in_flight = 1'b0;
        end
      end else begin
        e0 = m0_req && (m0_write || !full);
        e1 = m1_req && (m1_write || !full);
        if (e0 || e1) begin
          g = (e0 && e1) ? !m_last : e1;
          m_in_flight = 1'b1;
          m_owner = g;
          m_last = g;
          m_w     = g ? m1_write : m0_write;
          m_addr  = g ? m1_address : m0_address;
          m_wdata = g ? m1_wdata : m0_wdata;
          if (g) grants1++; else grants0++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    m0_req = 0; m0_write = 0; m0_address = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_address = '0; m1_wdata = '0;
    inb_rdata = '0; inb_datavalid = 0; inb_initdone = 0;
    repeat (3) tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_orphan, 0);
    chk("rst_inb_read", inb_read, 0);
    chk("rst_inb_address", inb_address, 0);

    // Single port-0 read with return data two cycles after acceptance.
    tick();
    rst_n = 1'b1;
    m0_req = 1; m0_write = 0; m0_address = 24'h000010; inb_initdone = 1;
    @(negedge clk);
    chk("t1_no_read_yet", inb_read, 0);
    tick();
    @(negedge clk);
    chk("t1_inb_read", inb_read, 1);
    chk("t1_m0_ack", m0_ack, 1);
    chk("t1_addr", inb_address, 24'h000010);
    tick();
    m0_req = 0;
    tick();
    inb_datavalid = 1; inb_rdata = 32'hA5A5A5A5;
    tick();
    inb_datavalid = 0;
    @(negedge clk);
    chk("t1_m0_rdv", m0_rdatavalid, 1);
    chk("t1_m0_rdata", m0_rdata, 32'hA5A5A5A5);
    chk("t1_m1_rdv", m1_rdatavalid, 0);

    // Randomized traffic; requesters hold each command until acked.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!m0_req || ack_seen0) begin
        m0_req = ($urandom_range(0, 3) != 0);
        m0_write = $urandom_range(0, 2) == 0;
        m0_address = AW'($urandom);
        m0_wdata = $urandom;
      end
      if (!m1_req || ack_seen1) begin
        m1_req = ($urandom_range(0, 3) != 0);
        m1_write = $urandom_range(0, 1) == 0;
        m1_address = AW'($urandom);
        m1_wdata = $urandom;
      end
      inb_initdone = ($urandom_range(0, 3) != 0);
      inb_datavalid = (tagq.size() != 0) &&
                      ((i < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
      inb_rdata = $urandom;
    end

    // Drain everything in flight.
    tick();
    m0_req = 0; m1_req = 0; inb_initdone = 1;
    guard = 0;
    while ((m_in_flight || tagq.size() != 0) && guard < 200) begin
      inb_datavalid = (tagq.size() != 0);
      inb_rdata = $urandom;
      tick();
      guard++;
    end
    inb_datavalid = 0;
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("grants_seen", (grants0 > 100) && (grants1 > 100), 1);

    // Orphan return data, then reset while a write is being held in ISSUE.
    tick();
    inb_datavalid = 1; inb_rdata = 32'hDEADBEEF;
    tick();
    inb_datavalid = 0;
    @(negedge clk);
    chk("orphan_err", err_orphan, 1);
    chk("orphan_no_rdv0", m0_rdatavalid, 0);
    chk("orphan_no_rdv1", m1_rdatavalid, 0);
    tick();
    m1_req = 1; m1_write = 1; m1_address = 24'h000020; m1_wdata = 32'h12345678; inb_initdone = 0;
    tick();
    @(negedge clk);
    chk("hold_inb_write", inb_write, 1);
    chk("hold_wdata", inb_wdata, 32'h12345678);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; m1_req = 0;
    @(negedge clk);
    chk("post_rst_write", inb_write, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_err", err_orphan, 0);
    chk("post_rst_wdata", inb_wdata, 0);
    chk("post_rst_m1_ack", m1_ack, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
